// File: rtl/text_char_feeder_if.sv
// CPU write port and renderer handshake bundle for text_char_feeder.
interface text_char_feeder_if #(
    parameter int DEPTH = 16
);
    logic                   i_wr;
    logic [1:0]             i_addr;
    logic [7:0]             i_wdata;
    logic                   i_display_done;
    logic                   o_update;
    logic [7:0]             o_ascii;
    logic [7:0]             o_text_attr;
    logic                   o_full;
    logic                   o_empty;
    logic [$clog2(DEPTH):0] o_level;
    logic                   o_ovf;
    logic                   o_tmo;

    modport master (
        output i_wr, i_addr, i_wdata, i_display_done,
        input  o_update, o_ascii, o_text_attr,
        input  o_full, o_empty, o_level, o_ovf, o_tmo
    );

    modport slave (
        input  i_wr, i_addr, i_wdata, i_display_done,
        output o_update, o_ascii, o_text_attr,
        output o_full, o_empty, o_level, o_ovf, o_tmo
    );
endinterface

// File: rtl/text_char_feeder.sv
// Character FIFO between a CPU write port and a text renderer,
// with a req/ack handshake, timeout and a two-cycle commit gap.
module text_char_feeder #(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] DEF_ATTR = 8'h0F,
    parameter int         TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    text_char_feeder_if.slave bus
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [7:0]    r_attr;
    logic [7:0]    r_ascii;
    logic [7:0]    r_text_attr;
    logic [7:0]    r_cnt;
    logic          r_gap;
    logic          r_update;
    logic          r_ovf;
    logic          r_tmo;

    logic w_full;
    logic w_empty;
    logic w_ctrl;
    logic w_flush;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_tmo_set;
    logic w_cnt_dec;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_ctrl  = bus.i_wr && (bus.i_addr == 2'd2);
    assign w_flush = w_ctrl && bus.i_wdata[2];
    assign w_push  = bus.i_wr && (bus.i_addr == 2'd0) && !w_full;
    assign w_drop  = bus.i_wr && (bus.i_addr == 2'd0) && w_full;

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_tmo_set = 1'b0;
        w_cnt_dec = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = REQ;
                end
            end
            REQ: begin
                if (bus.i_display_done) begin
                    w_next = ACK;
                end else if (r_cnt == 8'd0) begin
                    w_tmo_set = 1'b1;
                    w_next    = GAP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ACK: begin
                if (!bus.i_display_done) w_next = GAP;
            end
            GAP: begin
                if (r_gap) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // o_update is registered from the next state so it tracks REQ exactly
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_update <= (w_next == REQ);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_gap <= 1'b0;
        end else begin
            if (w_pop) r_cnt <= TMO;
            else if (w_cnt_dec) r_cnt <= r_cnt - 8'd1;
            r_gap <= (r_state == GAP) ? !r_gap : 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= {r_attr, bus.i_wdata};
    end

    // a flush only resets occupancy; the entry popped this edge still leaves
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ascii     <= '0;
            r_text_attr <= '0;
        end else if (w_pop) begin
            {r_text_attr, r_ascii} <= r_mem[r_rptr];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_attr <= DEF_ATTR;
        end else if (bus.i_wr && (bus.i_addr == 2'd1)) begin
            r_attr <= bus.i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_tmo <= 1'b0;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            else if (w_ctrl && bus.i_wdata[0]) r_ovf <= 1'b0;
            if (w_tmo_set) r_tmo <= 1'b1;
            else if (w_ctrl && bus.i_wdata[1]) r_tmo <= 1'b0;
        end
    end

    assign bus.o_update    = r_update;
    assign bus.o_ascii     = r_ascii;
    assign bus.o_text_attr = r_text_attr;
    assign bus.o_full      = w_full;
    assign bus.o_empty     = w_empty;
    assign bus.o_level     = r_level;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_tmo       = r_tmo;
endmodule

// File: tb/tb_text_char_feeder.sv
// Bench for text_char_feeder: fixed vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_text_char_feeder;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    text_char_feeder_if #(.DEPTH(DEPTH)) bus ();

    text_char_feeder #(
        .DEPTH(DEPTH), .DEF_ATTR(8'h0F), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic       done;
        logic       upd;
        logic [7:0] asc;
        logic [7:0] att;
        logic [4:0] lvl;
    } vec_t;

    vec_t tv[20];

    // reference model state
    logic [15:0] mq[$];
    logic [7:0]  m_attr;
    logic        m_ovf;
    logic        m_fl;
    logic        m_fl_valid;
    logic [15:0] m_fl_front;
    logic        prev_upd;
    logic [15:0] prev_char;
    int          cyc;
    int          last_rise;
    int          rises;

    function automatic vec_t v(input logic wr, input logic [1:0] a,
                               input logic [7:0] d, input logic dn,
                               input logic u, input logic [7:0] c,
                               input logic [7:0] t, input logic [4:0] l);
        vec_t r;
        r.wr = wr; r.addr = a; r.data = d; r.done = dn;
        r.upd = u; r.asc = c; r.att = t; r.lvl = l;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_attr    = 8'h0F;
        m_ovf     = 1'b0;
        m_fl      = 1'b0;
        prev_upd  = 1'b0;
        prev_char = 16'h0000;
        cyc       = 0;
        last_rise = -100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_wr = 1'b0;
        bus.i_display_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ack: 0 = never, 1 = one cycle after o_update, 2 = random
    task automatic step(input logic wr, input logic [1:0] addr,
                        input logic [7:0] data, input int ack);
        logic        rise;
        logic        have;
        logic [15:0] exp_c;
        logic [4:0]  el;
        bus.i_wr    = wr;
        bus.i_addr  = addr;
        bus.i_wdata = data;
        if (ack == 0) bus.i_display_done = 1'b0;
        else if (ack == 1) bus.i_display_done = bus.o_update;
        else bus.i_display_done = bus.o_update && ($urandom_range(0, 1) == 1);
        m_fl = 1'b0;
        if (wr) begin
            case (addr)
                2'd0: begin
                    if (mq.size() == DEPTH) m_ovf = 1'b1;
                    else mq.push_back({m_attr, data});
                end
                2'd1: m_attr = data;
                2'd2: begin
                    if (data[0]) m_ovf = 1'b0;
                    if (data[2]) begin
                        m_fl       = 1'b1;
                        m_fl_valid = (mq.size() > 0);
                        if (m_fl_valid) m_fl_front = mq[0];
                        mq.delete();
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        bus.i_wr = 1'b0;
        cyc++;
        rise = bus.o_update && !prev_upd;
        if (rise) begin
            rises++;
            have = m_fl ? m_fl_valid : (mq.size() > 0);
            if (!have) begin
                total++;
                bad++;
                $display("FAIL spurious_char: got %0h expected none",
                         {bus.o_text_attr, bus.o_ascii});
            end else begin
                exp_c = m_fl ? m_fl_front : mq.pop_front();
                chk("char", {bus.o_text_attr, bus.o_ascii}, exp_c);
            end
            if (last_rise >= 0) chk("spacing_ge5", 32'(cyc - last_rise >= 5), 1);
            last_rise = cyc;
        end else begin
            chk("data_stable", {bus.o_text_attr, bus.o_ascii}, prev_char);
        end
        el = 5'(mq.size());
        chk("status", {bus.o_level, bus.o_full, bus.o_empty, bus.o_ovf},
            {el, el == 5'(DEPTH), el == 5'd0, m_ovf});
        prev_upd  = bus.o_update;
        prev_char = {bus.o_text_attr, bus.o_ascii};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int lo;
        int g;
        int r0;
        logic [1:0] a;
        logic [7:0] d;

        tv[0]  = v(1, 0, 8'h41, 0, 0, 8'h00, 8'h00, 1);
        tv[1]  = v(0, 0, 8'h00, 0, 1, 8'h41, 8'h0F, 0);
        tv[2]  = v(0, 0, 8'h00, 0, 1, 8'h41, 8'h0F, 0);
        tv[3]  = v(0, 0, 8'h00, 1, 0, 8'h41, 8'h0F, 0);
        tv[4]  = v(0, 0, 8'h00, 0, 0, 8'h41, 8'h0F, 0);
        tv[5]  = v(0, 0, 8'h00, 0, 0, 8'h41, 8'h0F, 0);
        tv[6]  = v(0, 0, 8'h00, 0, 0, 8'h41, 8'h0F, 0);
        tv[7]  = v(1, 0, 8'h50, 0, 0, 8'h41, 8'h0F, 1);
        tv[8]  = v(1, 1, 8'h1E, 0, 1, 8'h50, 8'h0F, 0);
        tv[9]  = v(1, 0, 8'h42, 0, 1, 8'h50, 8'h0F, 1);
        tv[10] = v(0, 0, 8'h00, 1, 0, 8'h50, 8'h0F, 1);
        tv[11] = v(0, 0, 8'h00, 0, 0, 8'h50, 8'h0F, 1);
        tv[12] = v(0, 0, 8'h00, 0, 0, 8'h50, 8'h0F, 1);
        tv[13] = v(0, 0, 8'h00, 0, 0, 8'h50, 8'h0F, 1);
        tv[14] = v(0, 0, 8'h00, 0, 1, 8'h42, 8'h1E, 0);
        tv[15] = v(0, 0, 8'h00, 1, 0, 8'h42, 8'h1E, 0);
        tv[16] = v(1, 3, 8'hFF, 0, 0, 8'h42, 8'h1E, 0);
        tv[17] = v(1, 2, 8'h07, 0, 0, 8'h42, 8'h1E, 0);
        tv[18] = v(0, 0, 8'h00, 0, 0, 8'h42, 8'h1E, 0);
        tv[19] = v(0, 0, 8'h00, 0, 0, 8'h42, 8'h1E, 0);

        rises = 0;
        bus.i_wr = 1'b0;
        bus.i_addr = 2'd0;
        bus.i_wdata = 8'h00;
        bus.i_display_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {bus.o_update, bus.o_ascii, bus.o_text_attr, bus.o_level,
             bus.o_empty, bus.o_full, bus.o_ovf, bus.o_tmo},
            {1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus.i_wr = tv[i].wr;
            bus.i_addr = tv[i].addr;
            bus.i_wdata = tv[i].data;
            bus.i_display_done = tv[i].done;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {bus.o_update, bus.o_ascii, bus.o_text_attr, bus.o_level,
                 bus.o_empty, bus.o_full, bus.o_ovf, bus.o_tmo},
                {tv[i].upd, tv[i].asc, tv[i].att, tv[i].lvl,
                 tv[i].lvl == 5'd0, 1'b0, 1'b0, 1'b0});
        end
        bus.i_wr = 1'b0;

        // overflow, then drain across the pointer wrap
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 0, 8'h80 + 8'(i), 0);
        chk("ovf_level16", {bus.o_level, bus.o_full}, {5'd16, 1'b1});
        step(1, 0, 8'hA0, 0);
        chk("ovf_set", bus.o_ovf, 1);
        step(1, 2, 8'h01, 0);
        chk("ovf_clear", bus.o_ovf, 0);
        repeat (90) step(0, 0, 8'h00, 1);
        chk("ovf_drained", bus.o_level, 0);

        // timeout
        do_reset();
        step(1, 0, 8'h55, 0);
        step(1, 0, 8'h56, 0);
        hi = 0;
        g = 0;
        while (bus.o_update && g < 400) begin
            hi++;
            g++;
            step(0, 0, 8'h00, 0);
        end
        chk("tmo_update_cycles", hi, TIMEOUT + 1);
        chk("tmo_set", bus.o_tmo, 1);
        lo = 0;
        g = 0;
        while (!bus.o_update && g < 20) begin
            lo++;
            g++;
            step(0, 0, 8'h00, 0);
        end
        chk("tmo_gap_cycles", lo, 3);
        chk("tmo_next_char", bus.o_ascii, 8'h56);
        step(1, 2, 8'h02, 1);
        chk("tmo_clear", bus.o_tmo, 0);
        repeat (6) step(0, 0, 8'h00, 1);

        // ordering with one-cycle ack
        do_reset();
        r0 = rises;
        for (int i = 0; i < 10; i++) step(1, 0, 8'h30 + 8'(i), 1);
        repeat (60) step(0, 0, 8'h00, 1);
        chk("order_count", rises - r0, 10);

        // reset mid-handshake
        do_reset();
        step(1, 0, 8'h61, 0);
        step(1, 0, 8'h62, 0);
        chk("pre_rst_req", {bus.o_update, bus.o_level}, {1'b1, 5'd1});
        rst = 1'b1;
        #1;
        chk("rst_async", {bus.o_update, bus.o_level, bus.o_empty},
            {1'b0, 5'd0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // flush during a handshake
        r0 = rises;
        step(1, 0, 8'h63, 0);
        step(1, 0, 8'h64, 0);
        step(1, 0, 8'h65, 0);
        step(1, 2, 8'h04, 0);
        repeat (3) step(0, 0, 8'h00, 0);
        repeat (20) step(0, 0, 8'h00, 1);
        chk("flush_one_char", rises - r0, 1);
        chk("flush_done", {bus.o_update, bus.o_level, bus.o_ascii},
            {1'b0, 5'd0, 8'h63});

        // flush on the same edge as a pop
        do_reset();
        step(1, 0, 8'h70, 0);
        step(1, 2, 8'h04, 1);
        repeat (8) step(0, 0, 8'h00, 1);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 2'd0;
                6, 7: a = 2'd1;
                8: begin
                    a = 2'd2;
                    if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
                end
                default: a = 2'd3;
            endcase
            step($urandom_range(0, 2) == 0, a, d, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/text_char_feeder.md
TEXT_CHAR_FEEDER -- requirements
Module: text_char_feeder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..64).
REQ-002 The module SHALL have parameter DEF_ATTR, default 8'h0F, meaning the attribute register value after reset.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent waiting for an acknowledge (1..255).
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_wr  in  1  CPU write strobe, one cycle per write.
REQ-007 i_addr  in  2  write target: 0 = push character, 1 = attribute register, 2 = control, 3 = ignored.
REQ-008 i_wdata  in  8  write data.
REQ-009 i_display_done  in  1  acknowledge from the text renderer.
REQ-010 o_update  out  1  character-valid request to the text renderer.
REQ-011 o_ascii  out  8  character code presented to the renderer.
REQ-012 o_text_attr  out  8  attribute byte presented to the renderer.
REQ-013 o_full / o_empty  out  1 each  FIFO status.
REQ-014 o_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 o_ovf  out  1  sticky flag: a push was dropped.
REQ-016 o_tmo  out  1  sticky flag: a handshake timed out.

Function
REQ-017 A write with i_addr=1 SHALL load i_wdata into the attribute register at that edge.
REQ-018 A write with i_addr=0 SHALL push {attribute register, i_wdata} as a 16-bit entry, using the attribute value held before that edge.
REQ-019 A push while o_full=1 (pre-edge) SHALL be dropped and set o_ovf, even if a pop occurs on the same edge.
REQ-020 A push and a pop on the same edge with the FIFO not full SHALL leave o_level unchanged.
REQ-021 A write with i_addr=2 SHALL clear o_ovf if wdata[0]=1, clear o_tmo if wdata[1]=1, and flush the FIFO (level=0) if wdata[2]=1.
REQ-022 A flush SHALL NOT abort a handshake in progress; a flush coinciding with a pop SHALL still deliver the popped entry.
REQ-023 The FSM SHALL have states IDLE, REQ, ACK and GAP.
REQ-024 IDLE: if o_empty=0, pop the head entry into {o_text_attr,o_ascii}, load the timeout counter to TIMEOUT, and go to REQ; otherwise stay.
REQ-025 REQ: o_update=1; if i_display_done=1, go to ACK; else if the counter is 0, set o_tmo and go to GAP; else decrement the counter.
REQ-026 ACK: o_update=0; go to GAP when i_display_done=0.
REQ-027 GAP: o_update=0 for exactly 2 cycles, then return to IDLE, so that the renderer can commit its buffer write.
REQ-028 o_update SHALL be a registered output that is 1 exactly while the state is REQ.
REQ-029 o_ascii and o_text_attr SHALL change only on a pop and SHALL stay stable from REQ through GAP.
REQ-030 Latency: a push at edge N into an empty FIFO with the FSM idle SHALL give o_update=1 after edge N+1.
REQ-031 Back-to-back characters SHALL be spaced at least 5 cycles apart, measured from one rising edge of o_update to the next.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH, and o_level SHALL reach DEPTH when the FIFO is full.

Reset
REQ-033 While i_rst=1, the state SHALL be IDLE and the FIFO SHALL be empty, regardless of the clock.
REQ-034 Reset values SHALL be: o_update=0, o_ascii=8'h00, o_text_attr=8'h00, o_empty=1, o_full=0, o_level=0, o_ovf=0, o_tmo=0, attribute register=DEF_ATTR.
REQ-035 A reset asserted mid-handshake SHALL drop o_update immediately and SHALL discard the in-flight entry.

Verification
REQ-036 Basic: after reset, write addr0=0x41 with an ack 2 cycles after o_update -> o_ascii=0x41, o_text_attr=0x0F, o_update high after edge N+1, and the FSM returns to IDLE.
REQ-037 Attribute: write addr1=0x1E, then addr0=0x42 -> renderer sees o_ascii=0x42 with o_text_attr=0x1E; entries pushed before the attribute write keep 0x0F.
REQ-038 Overflow: 17 pushes with no ack and DEPTH=16 (one entry popped to REQ) -> o_level=16 and o_full=1; an 18th push sets o_ovf=1; addr2=0x01 clears o_ovf.
REQ-039 Timeout: one push with i_display_done held at 0 -> o_update stays high for TIMEOUT+1 cycles, then o_tmo=1 and the next entry proceeds after GAP.
REQ-040 Ordering: push 0x30..0x39 with a renderer model that acks after 1 cycle -> characters delivered in order, each rising edge of o_update at least 5 cycles after the previous one.
REQ-041 Reset/flush: assert i_rst while in REQ -> o_update=0 in the same cycle and o_level=0; after release, addr2=0x04 during a handshake -> the current character completes and the queue is empty.
